// File: rtl/jk_pkg.sv
// Shared definitions for the J-K command driver: op encodings, FSM state
// type, the command record and the J-K next-state rule used by both the
// scoreboard and the bench.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Default command length width; matches the driver's CNT_W default.
    localparam int JK_LEN_W = 8;

    typedef struct packed {
        logic [1:0]          op;
        logic [JK_LEN_W-1:0] len;
    } jk_cmd_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } jk_state_t;

    // Next q of a J-K flop: 00 hold, 01 reset, 10 set, 11 toggle.
    function automatic logic jk_next_q(input logic q, input logic j, input logic k);
        logic nq;
        case ({j, k})
            2'b00:   nq = q;
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            default: nq = ~q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO. Registered count drives full/empty, so a push
// into an empty FIFO becomes visible to the reader one edge later (no
// bypass). Storage is not reset; only pointers and count are.
module jk_cmd_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 10,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/jk_cmd_driver.sv
// J-K stimulus driver: queues {op,len} commands and holds the matching
// registered j/k pattern for max(len,1) cycles, back-to-back without gaps.
// Optional scoreboard (macro JK_SCOREBOARD_EN) models the flop's q and sets
// a sticky mismatch flag when the real q disagrees once q is known.
module jk_cmd_driver
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    output logic             busy,
    input  logic             q_in,
    output logic             exp_q,
    output logic             mismatch
);

    localparam int CMD_W = 2 + CNT_W;
    localparam int PTR_W = $clog2(DEPTH);

    logic [CMD_W-1:0] fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_count_unused;
    logic [1:0]       pop_op;
    logic [CNT_W-1:0] pop_len;

    jk_state_t        state_q, state_d;
    logic             j_q, j_d, k_q, k_d;
    logic [CNT_W-1:0] remain_q, remain_d;

    // A zero length still drives one cycle, so the countdown starts at len-1.
    function automatic logic [CNT_W-1:0] first_remain(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    assign cmd_ready = rst & ~fifo_full;
    assign pop_op    = fifo_rdata[CMD_W-1:CNT_W];
    assign pop_len   = fifo_rdata[CNT_W-1:0];
    // Occupancy is available for debug probing but not needed by the FSM.
    assign fifo_count_unused = ^fifo_count;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid & cmd_ready),
        .push_data ({cmd_op, cmd_len}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state logic: load on pop, count down while driving, chain the next
    // command on the final cycle so consecutive patterns are contiguous.
    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        k_d      = k_q;
        remain_d = remain_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                j_d = 1'b0;
                k_d = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    j_d      = (pop_op == JK_SET) || (pop_op == JK_TOG);
                    k_d      = (pop_op == JK_RST) || (pop_op == JK_TOG);
                    remain_d = first_remain(pop_len);
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (remain_q != '0) begin
                    remain_d = remain_q - 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    j_d      = (pop_op == JK_SET) || (pop_op == JK_TOG);
                    k_d      = (pop_op == JK_RST) || (pop_op == JK_TOG);
                    remain_d = first_remain(pop_len);
                end else begin
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                j_d     = 1'b0;
                k_d     = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and drive registers; reset aborts any in-flight command.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    // Countdown register; always loaded before it is consulted.
    always_ff @(posedge clk) begin
        remain_q <= remain_d;
    end

    assign j    = j_q;
    assign k    = k_q;
    assign busy = (state_q == ST_DRIVE);

`ifdef JK_SCOREBOARD_EN
    logic exp_q_q, exp_q_d, exp_known_q, exp_known_d, mismatch_q, mismatch_d;

    // Model the flop from the j/k being driven; compare only once a set or
    // reset has made the modelled value meaningful.
    always_comb begin
        exp_q_d     = jk_next_q(exp_q_q, j_q, k_q);
        exp_known_d = exp_known_q | (j_q ^ k_q);
        mismatch_d  = mismatch_q | (exp_known_q & (q_in != exp_q_q));
    end

    // Scoreboard state, cleared by reset; mismatch is sticky until then.
    always_ff @(posedge clk) begin
        if (!rst) begin
            exp_q_q     <= 1'b0;
            exp_known_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            exp_q_q     <= exp_q_d;
            exp_known_q <= exp_known_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign exp_q    = exp_q_q;
    assign mismatch = mismatch_q;
`else
    logic q_in_unused;
    assign q_in_unused = q_in;
    assign exp_q       = 1'b0;
    assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Bench for jk_cmd_driver: table-driven single commands, directed corner
// sequences and a randomized run checked every cycle against a timeline
// model (each command starts at max(push+1, previous end)).
module tb_jk_cmd_driver;
    import jk_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_len = '0;
    logic cmd_ready, j, k, busy, q_in, exp_q, mismatch;
    logic q_flop = 1'b0;
    logic inv = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Stand-in for the downstream J-K flop fed by the driver.
    always_ff @(posedge clk) begin
        if (!rst) q_flop <= 1'b0;
        else      q_flop <= jk_next_q(q_flop, j, k);
    end
    assign q_in = q_flop ^ inv;

    jk_cmd_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .busy(busy),
        .q_in(q_in), .exp_q(exp_q), .mismatch(mismatch)
    );

    // ---------------- reference model ----------------
    typedef struct { logic [1:0] op; int start; int stop; } ev_t;
    ev_t evq[$];
    int  t = 0;
    int  last_end = 0;
    int  m_cnt = 0;
    logic m_j = 1'b0, m_k = 1'b0, m_busy = 1'b0;
    logic m_expq = 1'b0, m_known = 1'b0, m_mm = 1'b0;
    bit  chk_on = 0;
    logic [2:0] obs[$];

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
        end
    endfunction

    task automatic model_edge();
        int len, s;
        t++;
        if (!rst) begin
            evq.delete();
            last_end = 0;
            m_expq = 1'b0; m_known = 1'b0; m_mm = 1'b0;
            chk_on = 1;
        end else begin
            if (cmd_valid && m_cnt < DEPTH) begin
                len = (cmd_len == 0) ? 1 : int'(cmd_len);
                s = (t + 1 > last_end) ? t + 1 : last_end;
                evq.push_back('{op: cmd_op, start: s, stop: s + len});
                last_end = s + len;
            end
`ifdef JK_SCOREBOARD_EN
            if (m_known && (q_in !== m_expq)) m_mm = 1'b1;
            m_expq = jk_next_q(m_expq, m_j, m_k);
            if (m_j ^ m_k) m_known = 1'b1;
`endif
        end
        while (evq.size() > 0 && evq[0].stop <= t) void'(evq.pop_front());
        m_j = 1'b0; m_k = 1'b0; m_busy = 1'b0; m_cnt = 0;
        foreach (evq[i]) begin
            if (evq[i].start <= t) begin
                m_busy = 1'b1;
                case (evq[i].op)
                    JK_RST:  begin m_j = 1'b0; m_k = 1'b1; end
                    JK_SET:  begin m_j = 1'b1; m_k = 1'b0; end
                    JK_TOG:  begin m_j = 1'b1; m_k = 1'b1; end
                    default: begin m_j = 1'b0; m_k = 1'b0; end
                endcase
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_all();
        if (chk_on) begin
            check("ready", cmd_ready, rst && (m_cnt < DEPTH));
            check("jk", {j, k}, {m_j, m_k});
            check("busy", busy, m_busy);
            check("exp_q", exp_q, m_expq);
            check("mismatch", mismatch, m_mm);
        end
    endtask

    // One cycle: check at the negedge, drive, step across the posedge.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] len, input logic r);
        check_all();
        obs.push_back({j, k, busy});
        cmd_valid = v; cmd_op = op; cmd_len = len; rst = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct { jk_cmd_t cmd; logic [1:0] exp_jk; int exp_cycles; } vec_t;
    vec_t vec[6];
    jk_cmd_t fifo_cmd[5];
    logic [2:0] exp_bb[5];
    logic [2:0] exp_ff[8];
    logic exp_sb[4];

    initial begin
        int n, skip, n_acc, t_long, t_e;
        logic acc, rv;
        logic [1:0] rop;
        logic [7:0] rlen;

        vec[0] = '{cmd: '{op: JK_SET,  len: 8'd3}, exp_jk: 2'b10, exp_cycles: 3};
        vec[1] = '{cmd: '{op: JK_RST,  len: 8'd1}, exp_jk: 2'b01, exp_cycles: 1};
        vec[2] = '{cmd: '{op: JK_TOG,  len: 8'd0}, exp_jk: 2'b11, exp_cycles: 1};
        vec[3] = '{cmd: '{op: JK_HOLD, len: 8'd2}, exp_jk: 2'b00, exp_cycles: 2};
        vec[4] = '{cmd: '{op: JK_TOG,  len: 8'd4}, exp_jk: 2'b11, exp_cycles: 4};
        vec[5] = '{cmd: '{op: JK_RST,  len: 8'd0}, exp_jk: 2'b01, exp_cycles: 1};
        fifo_cmd[0] = '{op: JK_TOG,  len: 8'd1};
        fifo_cmd[1] = '{op: JK_RST,  len: 8'd2};
        fifo_cmd[2] = '{op: JK_HOLD, len: 8'd1};
        fifo_cmd[3] = '{op: JK_SET,  len: 8'd1};
        fifo_cmd[4] = '{op: JK_TOG,  len: 8'd2};
        exp_bb = '{3'b011, 3'b011, 3'b111, 3'b001, 3'b000};
        exp_ff = '{3'b111, 3'b011, 3'b011, 3'b001, 3'b101, 3'b111, 3'b111, 3'b000};
        exp_sb = '{1'b1, 1'b0, 1'b1, 1'b0};

        @(negedge clk);
        cyc(0, 2'b00, 8'd0, 1'b0);
        cyc(0, 2'b00, 8'd0, 1'b0);
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_jk", {j, k}, 2'b00);
        check("rst_busy", busy, 1'b0);
        cyc(0, 2'b00, 8'd0, 1'b1);
        check("post_rst_ready", cmd_ready, 1'b1);

        // Single commands from the table.
        foreach (vec[i]) begin
            cyc(1, vec[i].cmd.op, vec[i].cmd.len, 1'b1);
            check("vec_nobypass", busy, 1'b0);
            cyc(0, 2'b00, 8'd0, 1'b1);
            n = 0;
            for (int c = 0; c < 300 && busy; c++) begin
                check("vec_jk", {j, k}, vec[i].exp_jk);
                n++;
                cyc(0, 2'b00, 8'd0, 1'b1);
            end
            check("vec_len", n, vec[i].exp_cycles);
            check("vec_end_jk", {j, k}, 2'b00);
        end

        // Back-to-back commands, contiguous pattern.
        cyc(1, JK_RST, 8'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      cyc(1, JK_TOG, 8'd1, 1'b1);
            else if (i == 1) cyc(1, JK_HOLD, 8'd0, 1'b1);
            else             cyc(0, 2'b00, 8'd0, 1'b1);
            check("b2b_seq", {j, k, busy}, exp_bb[i]);
        end

        // Fill the FIFO behind a long command.
        cyc(1, JK_SET, 8'd255, 1'b1);
        t_long = t;
        cyc(0, 2'b00, 8'd0, 1'b1);
        check("long_busy", busy, 1'b1);
        obs.delete();
        n_acc = 0;
        t_e = 0;
        for (int c = 0; c < 400 && n_acc < 5; c++) begin
            acc = (m_cnt < DEPTH);
            cyc(1, fifo_cmd[n_acc].op, fifo_cmd[n_acc].len, 1'b1);
            if (acc) begin
                n_acc++;
                if (n_acc == 4) check("full_ready_low", cmd_ready, 1'b0);
                if (n_acc == 5) t_e = t;
            end
        end
        check("fifth_accept_edge", t_e - t_long, 257);
        for (int c = 0; c < 12; c++) cyc(0, 2'b00, 8'd0, 1'b1);
        skip = 0;
        while (skip < obs.size() && obs[skip] == 3'b101) skip++;
        check("long_len", skip, 255);
        for (int i = 0; i < 8; i++)
            check("fifo_order", (skip + i < obs.size()) ? obs[skip + i] : 3'bxxx, exp_ff[i]);

        // Reset in the middle of a drive with two commands queued.
        cyc(1, JK_SET, 8'd20, 1'b1);
        cyc(1, JK_TOG, 8'd3, 1'b1);
        cyc(1, JK_RST, 8'd3, 1'b1);
        check("pre_rst_busy", busy, 1'b1);
        cyc(0, 2'b00, 8'd0, 1'b0);
        check("mid_rst_jk", {j, k}, 2'b00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", cmd_ready, 1'b0);
        cyc(1, JK_SET, 8'd1, 1'b0);
        check("mid_rst_ready2", cmd_ready, 1'b0);
        cyc(0, 2'b00, 8'd0, 1'b1);
        check("rel_ready", cmd_ready, 1'b1);
        for (int c = 0; c < 3; c++) begin
            cyc(0, 2'b00, 8'd0, 1'b1);
            check("rel_empty_busy", busy, 1'b0);
        end

`ifdef JK_SCOREBOARD_EN
        // Toggle before any set/reset: q unknown, never flagged.
        cyc(0, 2'b00, 8'd0, 1'b0);
        cyc(0, 2'b00, 8'd0, 1'b1);
        cyc(1, JK_TOG, 8'd2, 1'b1);
        for (int c = 0; c < 6; c++) begin
            inv = 1'($urandom_range(0, 1));
            cyc(0, 2'b00, 8'd0, 1'b1);
            check("sb_unknown_mm", mismatch, 1'b0);
        end
        inv = 1'b0;
        cyc(1, JK_SET, 8'd1, 1'b1);
        cyc(1, JK_TOG, 8'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 2'b00, 8'd0, 1'b1);
            check("sb_exp_q", exp_q, exp_sb[i]);
            check("sb_no_mm", mismatch, 1'b0);
        end
        inv = 1'b1;
        cyc(0, 2'b00, 8'd0, 1'b1);
        inv = 1'b0;
        check("sb_mm_set", mismatch, 1'b1);
        for (int c = 0; c < 3; c++) begin
            cyc(0, 2'b00, 8'd0, 1'b1);
            check("sb_mm_sticky", mismatch, 1'b1);
        end
        cyc(0, 2'b00, 8'd0, 1'b0);
        check("sb_mm_cleared", mismatch, 1'b0);
        cyc(0, 2'b00, 8'd0, 1'b1);
`endif

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rv   = ($urandom_range(0, 2) != 0);
            rop  = 2'($urandom_range(0, 3));
            rlen = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 4));
            inv  = ($urandom_range(0, 19) == 0);
            cyc(rv, rop, rlen, ($urandom_range(0, 199) != 0));
        end
        inv = 1'b0;
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
